ddc_acq_ctrl: RTL

Acquisition sequencer for the DDC datapath. It drives the DDC CIC activity (act) and decimation-strobe (act_out) inputs at a programmed rate. It arms on a start command, waits for a trigger, discards the CIC settling outputs, then counts a programmed number of valid DDC output samples. It sits between the register/host interface and the ddc instance, and shares the ddc clock and clock enable.

---
 rtl/ddc_acq_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ddc_acq_ctrl.sv
// Acquisition sequencer for the DDC: arm, trigger, CIC settle, capture N samples.
// Optional macro DDC_ACQ_CTRL_TRIG_SYNC_EN adds a trigger synchronizer and rising-edge detector.
module ddc_acq_ctrl #(
  parameter int RATE_WIDTH     = 7,
  parameter int CNT_WIDTH      = 16,
  parameter int SETTLE_OUTPUTS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic [CNT_WIDTH-1:0]  nsamples_i,
  input  logic                  trig_i,
  input  logic                  val_i,
  output logic                  act_o,
  output logic                  act_out_o,
  output logic                  keep_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  sample_cnt_o
);

  localparam int SW = $clog2(SETTLE_OUTPUTS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [RATE_WIDTH-1:0] r_rate, w_rate_nxt;
  logic [RATE_WIDTH-1:0] r_dcnt, w_dcnt_nxt;
  logic [CNT_WIDTH-1:0]  r_nsamples, w_nsamples_nxt;
  logic [CNT_WIDTH-1:0]  r_sample_cnt, w_sample_cnt_nxt;
  logic [SW-1:0]         r_scnt, w_scnt_nxt;
  logic                  r_act, w_act_nxt;
  logic                  r_act_out, w_act_out_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_busy;
  logic                  w_trig;

`ifdef DDC_ACQ_CTRL_TRIG_SYNC_EN
  // Two synchronizer flops plus one history flop for rising-edge detection.
  logic [2:0] r_trig_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_trig_sync <= '0;
    else if (en_i) r_trig_sync <= {r_trig_sync[1:0], trig_i};
  end

  assign w_trig = r_trig_sync[1] & ~r_trig_sync[2];
`else
  assign w_trig = trig_i;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_rate_nxt       = r_rate;
    w_nsamples_nxt   = r_nsamples;
    w_dcnt_nxt       = r_dcnt;
    w_scnt_nxt       = r_scnt;
    w_sample_cnt_nxt = r_sample_cnt;
    w_act_nxt        = r_act;
    w_act_out_nxt    = 1'b0;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
      w_act_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_rate_nxt     = rate_i;
            w_nsamples_nxt = nsamples_i;
            if (rate_i < RATE_WIDTH'(2) || nsamples_i == '0) begin
              w_err_nxt = 1'b1;
            end else begin
              w_state_nxt      = S_ARMED;
              w_sample_cnt_nxt = '0;
            end
          end
        end
        S_ARMED: begin
          if (w_trig) begin
            w_state_nxt = S_SETTLE;
            w_act_nxt   = 1'b1;
            w_dcnt_nxt  = '0;
            w_scnt_nxt  = '0;
          end
        end
        S_SETTLE, S_CAPTURE: begin
          // Strobe is registered from the terminal count, so it lands rate cycles after trigger.
          w_act_out_nxt = (r_dcnt == r_rate - 1'b1);
          w_dcnt_nxt    = (r_dcnt == r_rate - 1'b1) ? '0 : r_dcnt + 1'b1;
          if (val_i) begin
            if (r_state == S_SETTLE) begin
              w_scnt_nxt = r_scnt + 1'b1;
              if (r_scnt == SW'(SETTLE_OUTPUTS - 1)) w_state_nxt = S_CAPTURE;
            end else begin
              w_sample_cnt_nxt = r_sample_cnt + 1'b1;
              if (r_sample_cnt + 1'b1 == r_nsamples) begin
                w_state_nxt   = S_DONE;
                w_act_nxt     = 1'b0;
                w_act_out_nxt = 1'b0;
                w_done_nxt    = 1'b1;
              end
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Abort bypasses the clock enable; everything else advances only when enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_rate       <= '0;
      r_nsamples   <= '0;
      r_dcnt       <= '0;
      r_scnt       <= '0;
      r_sample_cnt <= '0;
      r_act        <= 1'b0;
      r_act_out    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else if (en_i || abort_i) begin
      r_state      <= w_state_nxt;
      r_rate       <= w_rate_nxt;
      r_nsamples   <= w_nsamples_nxt;
      r_dcnt       <= w_dcnt_nxt;
      r_scnt       <= w_scnt_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_act        <= w_act_nxt;
      r_act_out    <= w_act_out_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign act_o        = r_act;
  assign act_out_o    = r_act_out;
  assign keep_o       = (r_state == S_CAPTURE) & val_i;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign sample_cnt_o = r_sample_cnt;

endmodule
